// File: rtl/mem_lsu_pkg.sv
// Shared constants for the memory stage: load/store size codes, FSM
// encodings and data bus widths.
package mem_lsu_pkg;

  localparam int unsigned LSU_DATA_W = 32;
  localparam int unsigned LSU_BE_W   = 4;
  localparam int unsigned LSU_REG_W  = 5;
  localparam int unsigned LSU_F3_W   = 3;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic for the memory stage.
// Ports:
//   funct3, addr_lo, store, store_data : request being presented (IDLE)
//   ld_funct3, ld_addr_lo, rdata       : captured load info + bus read word
//   be, wdata                          : byte enables / lane-replicated data
//   load_data                          : extracted and extended load result
//   err                                : misaligned access or illegal funct3
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [LSU_F3_W-1:0]   funct3,
  input  logic [1:0]            addr_lo,
  input  logic                  store,
  input  logic [LSU_DATA_W-1:0] store_data,
  input  logic [LSU_F3_W-1:0]   ld_funct3,
  input  logic [1:0]            ld_addr_lo,
  input  logic [LSU_DATA_W-1:0] rdata,
  output logic [LSU_BE_W-1:0]   be,
  output logic [LSU_DATA_W-1:0] wdata,
  output logic [LSU_DATA_W-1:0] load_data,
  output logic                  err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Request side: enables, store replication, legality.
  always_comb begin
    be    = '0;
    wdata = '0;
    err   = 1'b0;
    case (funct3)
      LSU_B, LSU_BU: begin
        be  = 4'b0001 << addr_lo;
        err = store && (funct3 == LSU_BU);
        if (store) wdata = {4{store_data[7:0]}};
      end
      LSU_H, LSU_HU: begin
        be  = addr_lo[1] ? 4'b1100 : 4'b0011;
        err = addr_lo[0] || (store && (funct3 == LSU_HU));
        if (store) wdata = {2{store_data[15:0]}};
      end
      LSU_W: begin
        be  = 4'b1111;
        err = |addr_lo;
        if (store) wdata = store_data;
      end
      default: err = 1'b1;
    endcase
  end

  // Response side: pick the addressed lane and extend.
  always_comb begin
    byte_sel  = rdata[8*ld_addr_lo +: 8];
    half_sel  = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (ld_funct3)
      LSU_B:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU:  load_data = {24'd0, byte_sel};
      LSU_H:   load_data = {{16{half_sel[15]}}, half_sel};
      LSU_HU:  load_data = {16'd0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory stage and MEM/WB register. Runs one req/ack bus transaction per
// load/store, stalls upstream until it completes, and passes non-memory
// results to writeback with one cycle of latency.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   valid_i .. wreg_data_i        : execute-stage outputs
//   stall_o                       : combinational upstream hold
//   dbus_*                        : data bus request / response
//   valid_o, wreg_*_o             : writeback tuple
//   access_err_o                  : misaligned / illegal access pulse
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic                 wmem_en_i,
  input  logic                 rmem_en_i,
  input  logic [ADDR_W-1:0]    mem_addr_i,
  input  logic [LSU_F3_W-1:0]  funct3_i,
  input  logic                 wreg_en_i,
  input  logic [LSU_REG_W-1:0] wreg_addr_i,
  input  logic [DATA_W-1:0]    wreg_data_i,
  output logic                 stall_o,
  output logic                 dbus_req_o,
  output logic                 dbus_we_o,
  output logic [ADDR_W-1:0]    dbus_addr_o,
  output logic [LSU_BE_W-1:0]  dbus_be_o,
  output logic [DATA_W-1:0]    dbus_wdata_o,
  input  logic                 dbus_ack_i,
  input  logic [DATA_W-1:0]    dbus_rdata_i,
  output logic                 valid_o,
  output logic                 wreg_en_o,
  output logic [LSU_REG_W-1:0] wreg_addr_o,
  output logic [DATA_W-1:0]    wreg_data_o,
  output logic                 access_err_o
);

  logic [0:0]           state, state_nxt;
  logic                 mem_op;
  logic                 accept, reject, done;
  logic [LSU_F3_W-1:0]  cap_funct3;
  logic [1:0]           cap_addr_lo;
  logic                 cap_load;
  logic                 cap_wreg_en;
  logic [LSU_REG_W-1:0] cap_wreg_addr;
  logic [LSU_BE_W-1:0]  al_be;
  logic [DATA_W-1:0]    al_wdata;
  logic [DATA_W-1:0]    al_load;
  logic                 al_err;

  assign mem_op = valid_i && (wmem_en_i || rmem_en_i);

  lsu_align u_align (
    .funct3     (funct3_i),
    .addr_lo    (mem_addr_i[1:0]),
    .store      (wmem_en_i),
    .store_data (wreg_data_i),
    .ld_funct3  (cap_funct3),
    .ld_addr_lo (cap_addr_lo),
    .rdata      (dbus_rdata_i),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .err        (al_err)
  );

  // Next state and upstream stall.
  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_op) begin
          if (al_err) begin
            reject = 1'b1;
          end else begin
            accept    = 1'b1;
            stall_o   = 1'b1;
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall_o = !dbus_ack_i;
        if (dbus_ack_i) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, bus request and writeback registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      dbus_req_o    <= 1'b0;
      dbus_we_o     <= 1'b0;
      dbus_addr_o   <= '0;
      dbus_be_o     <= '0;
      dbus_wdata_o  <= '0;
      valid_o       <= 1'b0;
      wreg_en_o     <= 1'b0;
      wreg_addr_o   <= '0;
      wreg_data_o   <= '0;
      access_err_o  <= 1'b0;
      cap_funct3    <= '0;
      cap_addr_lo   <= '0;
      cap_load      <= 1'b0;
      cap_wreg_en   <= 1'b0;
      cap_wreg_addr <= '0;
    end else begin
      state        <= state_nxt;
      valid_o      <= 1'b0;
      wreg_en_o    <= 1'b0;
      access_err_o <= 1'b0;

      if (state == ST_IDLE && valid_i && !mem_op) begin
        valid_o     <= 1'b1;
        wreg_en_o   <= wreg_en_i;
        wreg_addr_o <= wreg_addr_i;
        wreg_data_o <= wreg_data_i;
      end

      if (reject) begin
        valid_o      <= 1'b1;
        access_err_o <= 1'b1;
      end

      // Store wins when both enables are set.
      if (accept) begin
        dbus_req_o    <= 1'b1;
        dbus_we_o     <= wmem_en_i;
        dbus_addr_o   <= {mem_addr_i[ADDR_W-1:2], 2'b00};
        dbus_be_o     <= al_be;
        dbus_wdata_o  <= al_wdata;
        cap_funct3    <= funct3_i;
        cap_addr_lo   <= mem_addr_i[1:0];
        cap_load      <= !wmem_en_i;
        cap_wreg_en   <= wreg_en_i;
        cap_wreg_addr <= wreg_addr_i;
      end

      if (done) begin
        dbus_req_o  <= 1'b0;
        valid_o     <= 1'b1;
        wreg_en_o   <= cap_load && cap_wreg_en;
        wreg_addr_o <= cap_wreg_addr;
        if (cap_load) wreg_data_o <= al_load;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases followed by randomized
// instructions, compared against an arithmetic reference model.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, wmem_en_i, rmem_en_i;
  logic [31:0] mem_addr_i;
  logic [2:0]  funct3_i;
  logic        wreg_en_i;
  logic [4:0]  wreg_addr_i;
  logic [31:0] wreg_data_i;
  logic        stall_o;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_ack_i;
  logic [31:0] dbus_rdata_i;
  logic        valid_o, wreg_en_o;
  logic [4:0]  wreg_addr_o;
  logic [31:0] wreg_data_o;
  logic        access_err_o;

  int total = 0;
  int bad   = 0;

  mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .wmem_en_i    (wmem_en_i),
    .rmem_en_i    (rmem_en_i),
    .mem_addr_i   (mem_addr_i),
    .funct3_i     (funct3_i),
    .wreg_en_i    (wreg_en_i),
    .wreg_addr_i  (wreg_addr_i),
    .wreg_data_i  (wreg_data_i),
    .stall_o      (stall_o),
    .dbus_req_o   (dbus_req_o),
    .dbus_we_o    (dbus_we_o),
    .dbus_addr_o  (dbus_addr_o),
    .dbus_be_o    (dbus_be_o),
    .dbus_wdata_o (dbus_wdata_o),
    .dbus_ack_i   (dbus_ack_i),
    .dbus_rdata_i (dbus_rdata_i),
    .valid_o      (valid_o),
    .wreg_en_o    (wreg_en_o),
    .wreg_addr_o  (wreg_addr_o),
    .wreg_data_o  (wreg_data_o),
    .access_err_o (access_err_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: access size in bytes (0 = no valid size).
  function automatic int unsigned size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit access_ok(input logic [31:0] a, input logic [2:0] f3, input bit st);
    int unsigned n;
    n = size_of(f3);
    if (n == 0) return 0;
    if (st && f3[2]) return 0;
    return (a % n) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] m;
    m = (32'd1 << size_of(f3)) - 32'd1;
    return 4'(m << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [2:0] f3);
    case (size_of(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [2:0] f3);
    int unsigned n;
    logic [31:0] sh, mask, v;
    n  = size_of(f3);
    sh = rd >> (8 * (a % 4));
    if (n == 4) return sh;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v    = sh & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, play the bus side, and check everything it produces.
  task automatic do_instr(input bit v, input bit we, input bit re, input logic [31:0] a,
                          input logic [2:0] f3, input bit wen, input logic [4:0] wa,
                          input logic [31:0] wd, input int ack_dly, input logic [31:0] rd);
    bit st, ld;
    valid_i = v; wmem_en_i = we; rmem_en_i = re; mem_addr_i = a; funct3_i = f3;
    wreg_en_i = wen; wreg_addr_i = wa; wreg_data_i = wd;
    #1;
    st = we;
    ld = re && !we;
    if (!v) begin
      check_eq("stall_idle", 32'(stall_o), 32'd0);
      step();
      check_eq("idle_valid", 32'(valid_o), 32'd0);
      check_eq("idle_wen", 32'(wreg_en_o), 32'd0);
      check_eq("idle_err", 32'(access_err_o), 32'd0);
    end else if (!(we || re)) begin
      check_eq("stall_alu", 32'(stall_o), 32'd0);
      step();
      check_eq("alu_valid", 32'(valid_o), 32'd1);
      check_eq("alu_wen", 32'(wreg_en_o), 32'(wen));
      check_eq("alu_waddr", 32'(wreg_addr_o), 32'(wa));
      check_eq("alu_wdata", wreg_data_o, wd);
      check_eq("alu_err", 32'(access_err_o), 32'd0);
    end else if (!access_ok(a, f3, st)) begin
      check_eq("stall_err", 32'(stall_o), 32'd0);
      step();
      check_eq("err_valid", 32'(valid_o), 32'd1);
      check_eq("err_wen", 32'(wreg_en_o), 32'd0);
      check_eq("err_flag", 32'(access_err_o), 32'd1);
      check_eq("err_req", 32'(dbus_req_o), 32'd0);
    end else begin
      check_eq("stall_acc", 32'(stall_o), 32'd1);
      step();
      check_eq("req", 32'(dbus_req_o), 32'd1);
      check_eq("we", 32'(dbus_we_o), 32'(st));
      check_eq("addr", dbus_addr_o, a & 32'hFFFF_FFFC);
      check_eq("be", 32'(dbus_be_o), 32'(model_be(a, f3)));
      check_eq("wdata", dbus_wdata_o, st ? model_wdata(wd, f3) : 32'd0);
      check_eq("acc_valid", 32'(valid_o), 32'd0);
      for (int i = 0; i < ack_dly; i++) begin
        check_eq("stall_wait", 32'(stall_o), 32'd1);
        step();
        check_eq("req_hold", 32'(dbus_req_o), 32'd1);
        check_eq("addr_hold", dbus_addr_o, a & 32'hFFFF_FFFC);
        check_eq("be_hold", 32'(dbus_be_o), 32'(model_be(a, f3)));
        check_eq("wait_valid", 32'(valid_o), 32'd0);
      end
      dbus_ack_i = 1'b1;
      dbus_rdata_i = rd;
      #1;
      check_eq("stall_ack", 32'(stall_o), 32'd0);
      step();
      dbus_ack_i = 1'b0;
      dbus_rdata_i = $urandom;
      check_eq("done_req", 32'(dbus_req_o), 32'd0);
      check_eq("done_valid", 32'(valid_o), 32'd1);
      check_eq("done_wen", 32'(wreg_en_o), ld ? 32'(wen) : 32'd0);
      check_eq("done_err", 32'(access_err_o), 32'd0);
      if (ld) begin
        check_eq("ld_waddr", 32'(wreg_addr_o), 32'(wa));
        check_eq("ld_data", wreg_data_o, model_load(rd, a, f3));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req"}, 32'(dbus_req_o), 32'd0);
    check_eq({tag, "_we"}, 32'(dbus_we_o), 32'd0);
    check_eq({tag, "_addr"}, dbus_addr_o, 32'd0);
    check_eq({tag, "_be"}, 32'(dbus_be_o), 32'd0);
    check_eq({tag, "_wdata"}, dbus_wdata_o, 32'd0);
    check_eq({tag, "_valid"}, 32'(valid_o), 32'd0);
    check_eq({tag, "_wen"}, 32'(wreg_en_o), 32'd0);
    check_eq({tag, "_waddr"}, 32'(wreg_addr_o), 32'd0);
    check_eq({tag, "_wdat"}, wreg_data_o, 32'd0);
    check_eq({tag, "_err"}, 32'(access_err_o), 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int          k;
    rst = 1'b1;
    valid_i = 0; wmem_en_i = 0; rmem_en_i = 0; mem_addr_i = 0; funct3_i = 0;
    wreg_en_i = 0; wreg_addr_i = 0; wreg_data_i = 0;
    dbus_ack_i = 0; dbus_rdata_i = 0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;

    // Directed cases.
    do_instr(1, 0, 0, 32'h0, 3'd0, 1, 5'd5, 32'h1234, 0, 0);
    do_instr(1, 0, 1, 32'h1003, 3'b000, 1, 5'd7, 0, 1, 32'h80FF_0000);
    do_instr(1, 0, 1, 32'h1003, 3'b100, 1, 5'd7, 0, 1, 32'h80FF_0000);
    do_instr(1, 1, 0, 32'h2002, 3'b001, 1, 5'd9, 32'hAAAA_BEEF, 3, 0);
    do_instr(1, 0, 1, 32'h3001, 3'b010, 1, 5'd3, 0, 0, 0);
    do_instr(1, 0, 1, 32'h3000, 3'b011, 1, 5'd3, 0, 0, 0);
    do_instr(1, 1, 0, 32'h3000, 3'b100, 0, 5'd3, 0, 0, 0);
    do_instr(1, 0, 1, 32'h4000, 3'b010, 1, 5'd10, 0, 2, 32'hDEAD_BEEF);
    do_instr(1, 0, 0, 32'h0, 3'd0, 1, 5'd11, 32'h0000_0042, 0, 0);
    do_instr(1, 0, 1, 32'h4002, 3'b001, 1, 5'd12, 0, 0, 32'h8001_7FFF);
    do_instr(1, 0, 1, 32'h4002, 3'b101, 1, 5'd12, 0, 0, 32'h8001_7FFF);

    // Reset while waiting on the bus; the later ack must be ignored.
    valid_i = 1; wmem_en_i = 0; rmem_en_i = 1; mem_addr_i = 32'h5000; funct3_i = 3'b010;
    wreg_en_i = 1; wreg_addr_i = 5'd4; wreg_data_i = 0;
    step();
    check_eq("rstw_req", 32'(dbus_req_o), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("rstw");
    valid_i = 0; dbus_ack_i = 1; dbus_rdata_i = 32'h1111_2222;
    #1;
    check_eq("rstw_stall", 32'(stall_o), 32'd0);
    step();
    dbus_ack_i = 0;
    check_eq("rstw_ack_req", 32'(dbus_req_o), 32'd0);
    check_eq("rstw_ack_valid", 32'(valid_o), 32'd0);
    do_instr(1, 0, 1, 32'h5001, 3'b000, 1, 5'd6, 0, 0, 32'h1234_5678);

    // Randomized instruction stream.
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      if ($urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      do_instr($urandom_range(0, 7) != 0, (k >= 7), ((k >= 4) && (k <= 6)) || (k == 9), a, f3,
               1'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom_range(0, 3), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
